// File: rtl/if_prefetch_queue_if.sv
// Instruction-memory fetch bus for if_prefetch_queue.
// Purpose: carries the request handshake (valid/ready/addr) and the in-order
//          response channel (valid/data) between the fetch front end and
//          instruction memory.
// Signals:
//   req_valid  fetch request valid (driven by the fetch unit)
//   req_ready  memory accepts the request this cycle
//   req_addr   word-aligned fetch byte address
//   resp_valid response valid; responses return in request order
//   resp_data  fetched instruction word
// Modports: master = fetch unit, slave = instruction memory.
interface if_prefetch_queue_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction fetch front end feeding the IF/ID register.
// Purpose: issues sequential word fetches, buffers in-order responses in a
//          DEPTH-entry circular queue and hands one instruction plus PC+4 per
//          cycle to decode. A taken branch redirects the PC, flushes the queue
//          and drops responses still in flight for the wrong path.
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active-low
//   imem          fetch bus (master side of if_prefetch_queue_if)
//   br_taken      EXE-stage taken branch: redirect and flush
//   br_addr       redirect target
//   id_stall      decode cannot accept this cycle
//   out_valid     out_instr/out_pc_plus4 valid for decode
//   out_instr     instruction at queue head (0 when not valid)
//   out_pc_plus4  head fetch address + 4 (0 when not valid)
//   queue_count   allocated entries, filled plus pending
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  if_prefetch_queue_if.master      imem,
  input  logic                     br_taken,
  input  logic [31:0]              br_addr,
  input  logic                     id_stall,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc_plus4,
  output logic [$clog2(DEPTH):0]   queue_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  logic [31:0]    pc;
  logic [31:0]    addr_q  [DEPTH];
  logic [31:0]    instr_q [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PW-1:0]  head, tail, fill_ptr;
  // alloc counts every allocated entry; pend counts the unfilled subset,
  // which is also the number of right-path responses still owed to us.
  logic [CW-1:0]  alloc, pend, discard_cnt;
  logic [CW-1:0]  alloc_next, pend_next, redirect_discard;
  logic           req_fire, pop, resp_fill, resp_drop;

  assign imem.req_valid = rst & ~br_taken & (alloc < DEPTH_C);
  assign imem.req_addr  = pc;
  assign req_fire       = imem.req_valid & imem.req_ready;

  assign out_valid    = rst & ~br_taken & filled[head];
  assign pop          = out_valid & ~id_stall;
  assign out_instr    = out_valid ? instr_q[head] : 32'h0;
  assign out_pc_plus4 = out_valid ? (addr_q[head] + 32'd4) : 32'h0;
  assign queue_count  = rst ? alloc : '0;

  // Wrong-path responses are consumed first; a response with nothing
  // pending and nothing to discard is a protocol error and is ignored.
  assign resp_drop = imem.resp_valid & ~br_taken & (discard_cnt != '0);
  assign resp_fill = imem.resp_valid & ~br_taken & (discard_cnt == '0) & (pend != '0);

  always_comb begin
    alloc_next = alloc;
    if (req_fire && !pop)      alloc_next = alloc + ONE_C;
    else if (!req_fire && pop) alloc_next = alloc - ONE_C;
  end

  always_comb begin
    pend_next = pend;
    if (req_fire && !resp_fill)      pend_next = pend + ONE_C;
    else if (!req_fire && resp_fill) pend_next = pend - ONE_C;
  end

  // On redirect every outstanding request becomes wrong-path; a response
  // arriving in the redirect cycle itself is one of them and is dropped now.
  always_comb begin
    redirect_discard = discard_cnt + pend;
    if (imem.resp_valid && (redirect_discard != '0))
      redirect_discard = redirect_discard - ONE_C;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      alloc       <= '0;
      pend        <= '0;
      discard_cnt <= '0;
      filled      <= '0;
    end else if (br_taken) begin
      pc          <= br_addr;
      head        <= tail;
      fill_ptr    <= tail;
      alloc       <= '0;
      pend        <= '0;
      discard_cnt <= redirect_discard;
      filled      <= '0;
    end else begin
      alloc <= alloc_next;
      pend  <= pend_next;
      if (req_fire) begin
        pc   <= pc + 32'd4;
        tail <= tail + ONE_P;
      end
      if (resp_drop)
        discard_cnt <= discard_cnt - ONE_C;
      if (resp_fill) begin
        filled[fill_ptr] <= 1'b1;
        fill_ptr         <= fill_ptr + ONE_P;
      end
      // Clearing on pop keeps a stale filled bit from showing up when the
      // head later wraps onto an entry that has not been reallocated yet.
      if (pop) begin
        filled[head] <= 1'b0;
        head         <= head + ONE_P;
      end
    end
  end

  // Entry payload carries no reset; validity lives entirely in filled/alloc.
  always_ff @(posedge clk) begin
    if (req_fire)
      addr_q[tail] <= pc;
    if (resp_fill)
      instr_q[fill_ptr] <= imem.resp_data;
  end
endmodule
